// File: rtl/axi_sram_pkg.sv
// Shared state encoding and beat sizing helpers for the AXI write-data to SRAM serializer.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [31:0] size_to_bytes(input logic [7:0] size);
    return 32'd1 << size;
  endfunction

  // A beat narrower than one SRAM word still occupies a single word write.
  function automatic logic [31:0] chunk_count(input logic [7:0] size, input logic [31:0] bpw);
    logic [31:0] bytes_v;
    bytes_v = size_to_bytes(size);
    if (bytes_v >= bpw) begin
      return bytes_v / bpw;
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/axi_sram_chunk_select.sv
// Lane mux: picks one SRAM-word slice of the AXI beat and its byte enables,
// with the sub-word mask clearing enables outside the beat's byte range.
module axi_sram_chunk_select
  import axi_sram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int SRAM_DATA_WIDTH = 8,
  localparam int BPW    = SRAM_DATA_WIDTH / 8,
  localparam int NWORDS = AXI_DATA_WIDTH / SRAM_DATA_WIDTH,
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic [AXI_DATA_WIDTH-1:0]   data,
  input  logic [AXI_DATA_WIDTH/8-1:0] strb,
  input  logic [IW-1:0]               idx,
  input  logic [BPW-1:0]              mask,
  output logic [SRAM_DATA_WIDTH-1:0]  wdata,
  output logic [BPW-1:0]              be
);

  // Slice selection for the word at index idx
  always_comb begin
    wdata = data[idx*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
    be    = strb[idx*BPW +: BPW] & mask;
  end

endmodule

// File: rtl/axi_sram_wdata_serializer.sv
// Serialises one captured AXI write beat into SRAM-word writes, skipping
// all-zero-strobe words and reporting beat/burst completion and size errors.
module axi_sram_wdata_serializer
  import axi_sram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int SRAM_DATA_WIDTH = 8,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int AXI_SIZE_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_addr,
  input  logic [AXI_SIZE_WIDTH-1:0]    s_size,
  input  logic [AXI_DATA_WIDTH-1:0]    s_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_strb,
  input  logic                         s_last,
  output logic                         sram_we,
  input  logic                         sram_ready,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_wdata,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be,
  output logic                         beat_done,
  output logic                         burst_done,
  output logic                         size_err
);

  localparam int LANES    = AXI_DATA_WIDTH / 8;
  localparam int BPW      = SRAM_DATA_WIDTH / 8;
  localparam int NWORDS   = AXI_DATA_WIDTH / SRAM_DATA_WIDTH;
  localparam int MAX_SIZE = $clog2(LANES);
  localparam int BPW_LOG  = $clog2(BPW);
  localparam int IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int KW       = $clog2(NWORDS) + 1;

  state_t                       state_r, state_nx_s;
  logic [AXI_DATA_WIDTH-1:0]    data_r;
  logic [LANES-1:0]             strb_r;
  logic [SRAM_ADDR_WIDTH-1:0]   base_r;
  logic [IW-1:0]                c0_r;
  logic [KW-1:0]                nchunks_r, k_r, k_nx_s;
  logic [BPW-1:0]               mask_r;
  logic                         last_r;

  logic                         sram_we_r, beat_done_r, burst_done_r, size_err_r, s_ready_r;
  logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_r;
  logic [SRAM_DATA_WIDTH-1:0]   sram_wdata_r;
  logic [BPW-1:0]               sram_be_r;

  logic [31:0]                  beat_bytes_s, lane_off_s;
  logic                         legal_s, load_s, size_bad_s, adv_s;
  logic [AXI_ADDR_WIDTH-1:0]    aligned_s;
  logic [IW-1:0]                c0_s;
  logic [SRAM_ADDR_WIDTH-1:0]   base_s;
  logic [KW-1:0]                nchunks_s;
  logic [BPW-1:0]               mask_s;

  logic [AXI_DATA_WIDTH-1:0]    sel_data_s;
  logic [LANES-1:0]             sel_strb_s;
  logic [IW-1:0]                sel_idx_s;
  logic [BPW-1:0]               sel_mask_s;
  logic [SRAM_ADDR_WIDTH-1:0]   sel_addr_s;
  logic [SRAM_DATA_WIDTH-1:0]   chunk_wdata_s;
  logic [BPW-1:0]               chunk_be_s;
  logic                         issue_nx_s, we_nx_s;

  // Decode of the beat presented on the slave port
  always_comb begin
    beat_bytes_s = size_to_bytes(8'(s_size));
    legal_s      = (32'(s_size) <= 32'(MAX_SIZE));
    aligned_s    = s_addr & ~AXI_ADDR_WIDTH'(beat_bytes_s - 32'd1);
    lane_off_s   = 32'(aligned_s) % 32'(LANES);
    c0_s         = IW'(lane_off_s / 32'(BPW));
    base_s       = SRAM_ADDR_WIDTH'(aligned_s >> BPW_LOG);
    nchunks_s    = KW'(chunk_count(8'(s_size), 32'(BPW)));
    if (beat_bytes_s < 32'(BPW)) begin
      mask_s = BPW'(((32'd1 << beat_bytes_s) - 32'd1) << (32'(aligned_s) % 32'(BPW)));
    end else begin
      mask_s = {BPW{1'b1}};
    end
  end

  // Next-state and chunk counter; an all-zero chunk retires without sram_ready
  always_comb begin
    state_nx_s = state_r;
    k_nx_s     = k_r;
    load_s     = 1'b0;
    size_bad_s = 1'b0;
    adv_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_valid && s_ready_r) begin
          if (legal_s) begin
            load_s     = 1'b1;
            k_nx_s     = {KW{1'b0}};
            state_nx_s = ISSUE;
          end else begin
            size_bad_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        adv_s = sram_we_r ? sram_ready : 1'b1;
        if (adv_s) begin
          if (k_r == nchunks_r - KW'(1'b1)) begin
            state_nx_s = DONE;
          end else begin
            k_nx_s = k_r + KW'(1'b1);
          end
        end else begin
          state_nx_s = ISSUE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Chunk to present next cycle: freshly loaded beat or the registered one
  always_comb begin
    if (load_s) begin
      sel_data_s = s_data;
      sel_strb_s = s_strb;
      sel_idx_s  = c0_s;
      sel_mask_s = mask_s;
      sel_addr_s = base_s;
    end else begin
      sel_data_s = data_r;
      sel_strb_s = strb_r;
      sel_idx_s  = c0_r + IW'(k_nx_s);
      sel_mask_s = mask_r;
      sel_addr_s = base_r + SRAM_ADDR_WIDTH'(k_nx_s);
    end
    issue_nx_s = (state_nx_s == ISSUE);
    we_nx_s    = issue_nx_s && (|chunk_be_s);
  end

  axi_sram_chunk_select #(
    .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
    .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH)
  ) u_chunk_select (
    .data  (sel_data_s),
    .strb  (sel_strb_s),
    .idx   (sel_idx_s),
    .mask  (sel_mask_s),
    .wdata (chunk_wdata_s),
    .be    (chunk_be_s)
  );

  // FSM state and captured beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      k_r       <= {KW{1'b0}};
      data_r    <= {AXI_DATA_WIDTH{1'b0}};
      strb_r    <= {LANES{1'b0}};
      base_r    <= {SRAM_ADDR_WIDTH{1'b0}};
      c0_r      <= {IW{1'b0}};
      nchunks_r <= {KW{1'b0}};
      mask_r    <= {BPW{1'b0}};
      last_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      k_r     <= k_nx_s;
      if (load_s) begin
        data_r    <= s_data;
        strb_r    <= s_strb;
        base_r    <= base_s;
        c0_r      <= c0_s;
        nchunks_r <= nchunks_s;
        mask_r    <= mask_s;
        last_r    <= s_last;
      end
    end
  end

  // Registered outputs, computed from the upcoming state so they line up with sram_we
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_we_r    <= 1'b0;
      sram_addr_r  <= {SRAM_ADDR_WIDTH{1'b0}};
      sram_wdata_r <= {SRAM_DATA_WIDTH{1'b0}};
      sram_be_r    <= {BPW{1'b0}};
      beat_done_r  <= 1'b0;
      burst_done_r <= 1'b0;
      size_err_r   <= 1'b0;
      s_ready_r    <= 1'b0;
    end else begin
      sram_we_r    <= we_nx_s;
      sram_addr_r  <= issue_nx_s ? sel_addr_s : {SRAM_ADDR_WIDTH{1'b0}};
      sram_wdata_r <= we_nx_s ? chunk_wdata_s : {SRAM_DATA_WIDTH{1'b0}};
      sram_be_r    <= issue_nx_s ? chunk_be_s : {BPW{1'b0}};
      beat_done_r  <= (state_nx_s == DONE);
      burst_done_r <= (state_nx_s == DONE) && last_r;
      size_err_r   <= size_bad_s;
      s_ready_r    <= (state_nx_s == IDLE);
    end
  end

  assign s_ready    = s_ready_r;
  assign sram_we    = sram_we_r;
  assign sram_addr  = sram_addr_r;
  assign sram_wdata = sram_wdata_r;
  assign sram_be    = sram_be_r;
  assign beat_done  = beat_done_r;
  assign burst_done = burst_done_r;
  assign size_err   = size_err_r;

endmodule

// File: tb/tb_axi_sram_wdata_serializer.sv
// Scoreboard bench: a 64/8 and a 64/32 instance; drivers queue expected SRAM
// writes and completions, negedge monitors pop and compare.
module tb_axi_sram_wdata_serializer;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        a_valid, a_ready, a_last, a_sram_we, a_sram_ready, a_beat_done, a_burst_done, a_size_err;
  logic [31:0] a_addr;
  logic [2:0]  a_size;
  logic [63:0] a_data;
  logic [7:0]  a_strb;
  logic [15:0] a_sram_addr;
  logic [7:0]  a_sram_wdata;
  logic [0:0]  a_sram_be;

  logic        b_valid, b_ready, b_last, b_sram_we, b_sram_ready, b_beat_done, b_burst_done, b_size_err;
  logic [31:0] b_addr;
  logic [2:0]  b_size;
  logic [63:0] b_data;
  logic [7:0]  b_strb;
  logic [15:0] b_sram_addr;
  logic [31:0] b_sram_wdata;
  logic [3:0]  b_sram_be;

  axi_sram_wdata_serializer #(.AXI_DATA_WIDTH(64), .SRAM_DATA_WIDTH(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_valid(a_valid), .s_ready(a_ready), .s_addr(a_addr),
    .s_size(a_size), .s_data(a_data), .s_strb(a_strb), .s_last(a_last), .sram_we(a_sram_we),
    .sram_ready(a_sram_ready), .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata),
    .sram_be(a_sram_be), .beat_done(a_beat_done), .burst_done(a_burst_done), .size_err(a_size_err)
  );

  axi_sram_wdata_serializer #(.AXI_DATA_WIDTH(64), .SRAM_DATA_WIDTH(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_valid(b_valid), .s_ready(b_ready), .s_addr(b_addr),
    .s_size(b_size), .s_data(b_data), .s_strb(b_strb), .s_last(b_last), .sram_we(b_sram_we),
    .sram_ready(b_sram_ready), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
    .sram_be(b_sram_be), .beat_done(b_beat_done), .burst_done(b_burst_done), .size_err(b_size_err)
  );

  int tests = 0;
  int fails = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  bit  done_a[$];
  bit  done_b[$];
  int  stall_cnt_a = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 64/8 instance: write scoreboard, stall hold, completion pulses
  wr_t snap_a;
  bit  stall_a = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    bit  eb;
    if (reset_n) begin
      if (stall_a)
        chk("hold_a", {a_sram_we, a_sram_addr, 24'h0, a_sram_wdata, 3'b0, a_sram_be},
                      {1'b1, snap_a.addr, snap_a.data, snap_a.be});
      stall_a = a_sram_we && !a_sram_ready;
      if (stall_a) begin
        snap_a = '{addr: a_sram_addr, data: {24'h0, a_sram_wdata}, be: {3'b0, a_sram_be}};
        stall_cnt_a++;
      end
      if (a_sram_we && a_sram_ready) begin
        if (exp_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_a_extra: write addr %0h data %0h, expected none", a_sram_addr, a_sram_wdata);
        end else begin
          e = exp_a.pop_front();
          chk("wr_a_addr", a_sram_addr, e.addr);
          chk("wr_a_data", a_sram_wdata, e.data);
          chk("wr_a_be", a_sram_be, e.be);
        end
      end
      if (a_beat_done) begin
        if (done_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_a_extra: beat_done=1, expected 0");
        end else begin
          eb = done_a.pop_front();
          chk("burst_a", a_burst_done, eb);
        end
      end else if (a_burst_done) begin
        tests++; fails++;
        $display("FAIL burst_a_alone: burst_done=1 without beat_done, expected 0");
      end
    end else begin
      stall_a = 1'b0;
    end
  end

  // Monitor for the 64/32 instance
  always @(negedge clk) begin
    wr_t e;
    bit  eb;
    if (reset_n) begin
      if (b_sram_we && b_sram_ready) begin
        if (exp_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_b_extra: write addr %0h data %0h, expected none", b_sram_addr, b_sram_wdata);
        end else begin
          e = exp_b.pop_front();
          chk("wr_b_addr", b_sram_addr, e.addr);
          chk("wr_b_data", b_sram_wdata, e.data);
          chk("wr_b_be", b_sram_be, e.be);
        end
      end
      if (b_beat_done) begin
        if (done_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_b_extra: beat_done=1, expected 0");
        end else begin
          eb = done_b.pop_front();
          chk("burst_b", b_burst_done, eb);
        end
      end
    end
  end

  task automatic send(input bit to_b, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    @(negedge clk);
    if (to_b) begin
      b_valid = 1'b1; b_addr = addr; b_size = size; b_data = data; b_strb = strb; b_last = last;
    end else begin
      a_valid = 1'b1; a_addr = addr; a_size = size; a_data = data; a_strb = strb; a_last = last;
    end
    n = 0;
    while (!(to_b ? b_ready : a_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the handshake edge
  task automatic wait_done(input bit to_b, output int n, output int first_we);
    n = 1;
    first_we = 0;
    @(negedge clk);
    while (!(to_b ? b_beat_done : a_beat_done) && n < 100) begin
      if ((to_b ? b_sram_we : a_sram_we) && first_we == 0) first_we = n;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    int n, fw;
    reset_n = 1'b0;
    a_valid = 1'b0; a_addr = 32'h0; a_size = 3'd0; a_data = 64'h0; a_strb = 8'h0; a_last = 1'b0;
    b_valid = 1'b0; b_addr = 32'h0; b_size = 3'd0; b_data = 64'h0; b_strb = 8'h0; b_last = 1'b0;
    a_sram_ready = 1'b1;
    b_sram_ready = 1'b1;
    #1;
    chk("rst_ready_a", a_ready, 0);
    chk("rst_outs_a", {a_sram_we, a_sram_addr, a_sram_wdata, a_sram_be, a_beat_done, a_burst_done, a_size_err}, 0);
    chk("rst_outs_b", {b_ready, b_sram_we, b_sram_addr, b_sram_wdata, b_sram_be, b_beat_done}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_a", a_ready, 1);

    // Full 64-bit beat on 8-bit SRAM, latency check
    for (int i = 0; i < 8; i++)
      exp_a.push_back('{addr: 16'(32'h100 + i), data: 32'((i + 1) * 17), be: 4'h1});
    done_a.push_back(1'b0);
    send(1'b0, 32'h100, 3'd3, 64'h8877665544332211, 8'hFF, 1'b0);
    wait_done(1'b0, n, fw);
    chk("t1_first_we_cyc", fw, 1);
    chk("t1_done_cyc", n, 9);
    @(negedge clk);
    chk("t1_ready_after", a_ready, 1);

    // 32-bit beat in the upper half
    exp_a.push_back('{addr: 16'h204, data: 32'hAA, be: 4'h1});
    exp_a.push_back('{addr: 16'h205, data: 32'hBB, be: 4'h1});
    exp_a.push_back('{addr: 16'h206, data: 32'hCC, be: 4'h1});
    exp_a.push_back('{addr: 16'h207, data: 32'hDD, be: 4'h1});
    done_a.push_back(1'b0);
    send(1'b0, 32'h204, 3'd2, 64'hDDCCBBAA_00000000, 8'hF0, 1'b0);
    wait_done(1'b0, n, fw);
    chk("t2_done_cyc", n, 5);

    // Half strobes, last beat: 4 writes, 4 skips, burst_done
    exp_a.push_back('{addr: 16'h300, data: 32'h11, be: 4'h1});
    exp_a.push_back('{addr: 16'h301, data: 32'h22, be: 4'h1});
    exp_a.push_back('{addr: 16'h302, data: 32'h33, be: 4'h1});
    exp_a.push_back('{addr: 16'h303, data: 32'h44, be: 4'h1});
    done_a.push_back(1'b1);
    send(1'b0, 32'h300, 3'd3, 64'hF0E0D0C0_44332211, 8'h0F, 1'b1);
    wait_done(1'b0, n, fw);
    chk("t3_done_cyc", n, 9);

    // All-zero strobes: only skip cycles
    done_a.push_back(1'b0);
    send(1'b0, 32'h380, 3'd3, 64'h1234567890ABCDEF, 8'h00, 1'b0);
    wait_done(1'b0, n, fw);
    chk("t4_done_cyc", n, 9);
    chk("t4_no_we", fw, 0);

    // SRAM back-pressure on chunk 2 for 3 cycles
    for (int i = 0; i < 8; i++)
      exp_a.push_back('{addr: 16'(32'h400 + i), data: 32'(i + 1), be: 4'h1});
    done_a.push_back(1'b0);
    send(1'b0, 32'h400, 3'd3, 64'h0807060504030201, 8'hFF, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(a_sram_we && a_sram_addr == 16'h401) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 a_sram_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 a_sram_ready = 1'b1;
    wait_done(1'b0, n, fw);
    chk("t5_stall_cycles", stall_cnt_a, 3);

    // Illegal size on the 64-bit bus
    send(1'b0, 32'h500, 3'd4, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    @(negedge clk);
    chk("t6_size_err", a_size_err, 1);
    chk("t6_ready", a_ready, 1);
    chk("t6_no_we", a_sram_we, 0);
    @(negedge clk);
    chk("t6_size_err_pulse", a_size_err, 0);

    // 64/32: sub-word, two-word and masked half-word beats
    exp_b.push_back('{addr: 16'h4, data: 32'hA5000000, be: 4'b1000});
    done_b.push_back(1'b0);
    send(1'b1, 32'h13, 3'd0, 64'h00000000_A5000000, 8'h08, 1'b0);
    wait_done(1'b1, n, fw);
    chk("b1_done_cyc", n, 2);
    exp_b.push_back('{addr: 16'h8, data: 32'h55667788, be: 4'hF});
    exp_b.push_back('{addr: 16'h9, data: 32'h11223344, be: 4'hF});
    done_b.push_back(1'b1);
    send(1'b1, 32'h20, 3'd3, 64'h11223344_55667788, 8'hFF, 1'b1);
    wait_done(1'b1, n, fw);
    chk("b2_done_cyc", n, 3);
    exp_b.push_back('{addr: 16'h5, data: 32'hCAFE1234, be: 4'b1100});
    done_b.push_back(1'b0);
    send(1'b1, 32'h16, 3'd1, 64'hCAFE1234_00000000, 8'hFF, 1'b0);
    wait_done(1'b1, n, fw);
    chk("b3_done_cyc", n, 2);

    // Reset mid-ISSUE: two writes then abort with no completion
    exp_a.push_back('{addr: 16'h600, data: 32'hA0, be: 4'h1});
    exp_a.push_back('{addr: 16'h601, data: 32'hA1, be: 4'h1});
    send(1'b0, 32'h600, 3'd3, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {a_sram_we, a_sram_addr, a_sram_wdata, a_sram_be, a_beat_done, a_burst_done, a_ready}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_mid_ready", a_ready, 1);

    chk("exp_a_empty", exp_a.size(), 0);
    chk("exp_b_empty", exp_b.size(), 0);
    chk("done_a_empty", done_a.size(), 0);
    chk("done_b_empty", done_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
